// File: rtl/dualport_ram_unaligned_if.sv
// Port bundle for one side of the unaligned dual-port RAM.
// Requester drives master; the RAM implements slave.
interface dualport_ram_unaligned_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  req;
  logic [BYTES-1:0]      we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/dualport_ram_unaligned.sv
// True dual-port byte-addressed RAM, registered reads.
// Accesses crossing a word boundary take two cycles.
module dualport_ram_unaligned #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter bit B_WINS     = 1'b1
) (
  input logic clk,
  input logic rst,
  dualport_ram_unaligned_if.slave a,
  dualport_ram_unaligned_if.slave b
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int WIDX  = ADDR_WIDTH - OFFW;
  localparam int WORDS = 2 ** WIDX;
  localparam int FIRST = B_WINS ? 0 : 1;
  localparam int LAST  = 1 - FIRST;

  typedef enum logic {IDLE, SPLIT} state_t;
  typedef logic [BYTES-1:0][7:0] word_t;

  word_t                 mem [WORDS];
  state_t                state_q [2];
  state_t                state_d [2];
  logic                  req [2];
  logic [BYTES-1:0]      we_in [2];
  logic [ADDR_WIDTH-1:0] addr_in [2];
  word_t                 wdata_in [2];
  logic [ADDR_WIDTH-1:0] lat_addr [2];
  logic [BYTES-1:0]      lat_we [2];
  word_t                 lat_wdata [2];
  word_t                 lo_q [2];
  word_t                 rdata_q [2];
  logic                  rvalid_q [2];
  logic                  in_split [2];
  logic                  accept [2];
  logic                  is_rd [2];
  logic                  need_split [2];
  logic [ADDR_WIDTH-1:0] cur_addr [2];
  logic [BYTES-1:0]      cur_we [2];
  word_t                 cur_wdata [2];
  logic [OFFW-1:0]       off [2];
  logic [WIDX-1:0]       word_idx [2];
  logic [2*BYTES-1:0]    lane_map [2];
  word_t                 wrot [2];
  logic [BYTES-1:0]      wmask [2];

  assign req[0]      = a.req;
  assign req[1]      = b.req;
  assign we_in[0]    = a.we;
  assign we_in[1]    = b.we;
  assign addr_in[0]  = a.addr;
  assign addr_in[1]  = b.addr;
  assign wdata_in[0] = a.wdata;
  assign wdata_in[1] = b.wdata;
  assign a.ready     = !in_split[0];
  assign b.ready     = !in_split[1];
  assign a.rdata     = rdata_q[0];
  assign b.rdata     = rdata_q[1];
  assign a.rvalid    = rvalid_q[0];
  assign b.rvalid    = rvalid_q[1];

  // lane i of the result is byte (o + i) of the pair {hi, lo}
  function automatic word_t assemble(
    input word_t lo,
    input word_t hi,
    input logic [OFFW-1:0] o
  );
    word_t res;
    logic [OFFW:0] k;
    for (int i = 0; i < BYTES; i++) begin
      k = {1'b0, o} + (OFFW+1)'(i);
      res[i] = k[OFFW] ? hi[k[OFFW-1:0]] : lo[k[OFFW-1:0]];
    end
    return res;
  endfunction

  // per-port access decode and FSM next state
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_split[p]  = state_q[p] == SPLIT;
      cur_addr[p]  = in_split[p] ? lat_addr[p] : addr_in[p];
      cur_we[p]    = in_split[p] ? lat_we[p] : we_in[p];
      cur_wdata[p] = in_split[p] ? lat_wdata[p] : wdata_in[p];
      off[p]       = cur_addr[p][OFFW-1:0];
      word_idx[p]  = cur_addr[p][ADDR_WIDTH-1:OFFW]
                   + {{(WIDX-1){1'b0}}, in_split[p]};
      lane_map[p]  = {{BYTES{1'b0}}, cur_we[p]} << off[p];
      for (int j = 0; j < BYTES; j++)
        wrot[p][j] = cur_wdata[p][OFFW'(j) - off[p]];
      is_rd[p]      = cur_we[p] == '0;
      need_split[p] = is_rd[p] ? (off[p] != '0)
                    : (lane_map[p][2*BYTES-1:BYTES] != '0);
      accept[p] = !rst && !in_split[p] && req[p];
      wmask[p]  = '0;
      if (!rst && in_split[p])
        wmask[p] = lane_map[p][2*BYTES-1:BYTES];
      else if (accept[p])
        wmask[p] = lane_map[p][BYTES-1:0];
      state_d[p] = state_q[p];
      if (in_split[p])
        state_d[p] = IDLE;
      else if (accept[p] && need_split[p])
        state_d[p] = SPLIT;
    end
  end

  // FSM state registers
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      state_q[p] <= rst ? IDLE : state_d[p];
  end

  // read path, request latching and rvalid pulse
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        rvalid_q[p] <= 1'b0;
        rdata_q[p]  <= '0;
      end else begin
        rvalid_q[p] <= 1'b0;
        if (accept[p]) begin
          lat_addr[p]  <= addr_in[p];
          lat_we[p]    <= we_in[p];
          lat_wdata[p] <= wdata_in[p];
          if (is_rd[p] && need_split[p]) begin
            lo_q[p] <= mem[word_idx[p]];
          end else if (is_rd[p]) begin
            rdata_q[p]  <= mem[word_idx[p]];
            rvalid_q[p] <= 1'b1;
          end
        end else if (in_split[p] && is_rd[p]) begin
          rdata_q[p]  <= assemble(lo_q[p], mem[word_idx[p]], off[p]);
          rvalid_q[p] <= 1'b1;
        end
      end
    end
  end

  // byte writes; the later loop overrides on a same-byte collision
  always_ff @(posedge clk) begin
    for (int j = 0; j < BYTES; j++)
      if (wmask[FIRST][j])
        mem[word_idx[FIRST]][j] <= wrot[FIRST][j];
    for (int j = 0; j < BYTES; j++)
      if (wmask[LAST][j])
        mem[word_idx[LAST]][j] <= wrot[LAST][j];
  end
endmodule

// File: tb/tb_dualport_ram_unaligned.sv
// Bench for dualport_ram_unaligned: byte-level reference model,
// scoreboard queues, directed cases then random traffic.
module tb_dualport_ram_unaligned;
  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int NB  = 4;
  localparam int MSZ = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req [2];
  logic [3:0]  we [2];
  logic [11:0] addr [2];
  logic [31:0] wdata [2];

  dualport_ram_unaligned_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1 ();
  dualport_ram_unaligned_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
  dualport_ram_unaligned_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a0 ();
  dualport_ram_unaligned_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();

  assign a1.req = req[0];   assign a0.req = req[0];
  assign b1.req = req[1];   assign b0.req = req[1];
  assign a1.we = we[0];     assign a0.we = we[0];
  assign b1.we = we[1];     assign b0.we = we[1];
  assign a1.addr = addr[0]; assign a0.addr = addr[0];
  assign b1.addr = addr[1]; assign b0.addr = addr[1];
  assign a1.wdata = wdata[0]; assign a0.wdata = wdata[0];
  assign b1.wdata = wdata[1]; assign b0.wdata = wdata[1];

  dualport_ram_unaligned #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .B_WINS(1'b1)
  ) dut1 (.clk(clk), .rst(rst), .a(a1), .b(b1));

  dualport_ram_unaligned #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .B_WINS(1'b0)
  ) dut0 (.clk(clk), .rst(rst), .a(a0), .b(b0));

  int checks = 0;
  int errors = 0;

  logic [7:0]  refm [2][MSZ];
  logic [31:0] part [2][2];
  logic [31:0] exq [4][$];
  bit          pend [2];
  logic [11:0] p_addr [2];
  logic [3:0]  p_we [2];
  logic [31:0] p_wd [2];

  function automatic logic [31:0] rd(int i, int p);
    if (i == 1) return (p == 0) ? a1.rdata : b1.rdata;
    return (p == 0) ? a0.rdata : b0.rdata;
  endfunction

  function automatic logic rv(int i, int p);
    if (i == 1) return (p == 0) ? a1.rvalid : b1.rvalid;
    return (p == 0) ? a0.rvalid : b0.rvalid;
  endfunction

  function automatic logic rdy(int i, int p);
    if (i == 1) return (p == 0) ? a1.ready : b1.ready;
    return (p == 0) ? a0.ready : b0.ready;
  endfunction

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: what happens at the coming posedge
  task automatic step();
    bit act [2];
    bit hf [2];
    bit fin [2];
    logic [11:0] ad [2];
    logic [3:0] w [2];
    logic [31:0] d [2];
    int o;
    int p;
    for (int i = 0; i < 2; i++)
      for (int q = 0; q < 2; q++)
        chk(rdy(i, q) === !pend[q], "ready",
            {31'd0, rdy(i, q)}, {31'd0, !pend[q]});
    for (int q = 0; q < 2; q++) begin
      act[q] = 0; hf[q] = 0; fin[q] = 0;
      ad[q] = '0; w[q] = '0; d[q] = '0;
      if (rst) begin
        pend[q] = 0;
      end else if (pend[q]) begin
        act[q] = 1; hf[q] = 1; fin[q] = 1;
        ad[q] = p_addr[q]; w[q] = p_we[q]; d[q] = p_wd[q];
        pend[q] = 0;
      end else if (req[q]) begin
        bit spl;
        act[q] = 1;
        ad[q] = addr[q]; w[q] = we[q]; d[q] = wdata[q];
        o = int'(ad[q]) % NB;
        spl = 0;
        for (int i = 0; i < NB; i++)
          if (w[q] == 0 ? (o != 0) : (w[q][i] && o + i >= NB)) spl = 1;
        if (spl) begin
          pend[q] = 1; p_addr[q] = ad[q]; p_we[q] = w[q]; p_wd[q] = d[q];
        end else begin
          fin[q] = 1;
        end
      end
    end
    for (int n = 0; n < 2; n++) begin
      for (int q = 0; q < 2; q++) begin
        if (act[q] && w[q] == 0) begin
          o = int'(ad[q]) % NB;
          for (int i = 0; i < NB; i++)
            if ((o + i < NB) == !hf[q])
              part[n][q][8*i +: 8] = refm[n][(int'(ad[q]) + i) % MSZ];
          if (fin[q]) exq[n*2+q].push_back(part[n][q]);
        end
      end
      for (int k = 0; k < 2; k++) begin
        p = (n == 1) ? k : 1 - k;
        if (act[p] && w[p] != 0) begin
          o = int'(ad[p]) % NB;
          for (int i = 0; i < NB; i++)
            if (w[p][i] && ((o + i < NB) == !hf[p]))
              refm[n][(int'(ad[p]) + i) % MSZ] = d[p][8*i +: 8];
        end
      end
    end
  endtask

  task automatic issue(input int p, input logic [3:0] w,
                       input logic [11:0] ad, input logic [31:0] d);
    req[p] = 1'b1; we[p] = w; addr[p] = ad; wdata[p] = d;
  endtask

  task automatic tick();
    step();
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    req[1] = 1'b0;
  endtask

  // monitor: compare every read response against the scoreboard
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++)
        if (rv(i, p) === 1'b1) begin
          if (exq[i*2+p].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_rvalid dut%0d port%0d got %h expected none",
                     i, p, rd(i, p));
          end else begin
            logic [31:0] e;
            e = exq[i*2+p].pop_front();
            chk(rd(i, p) === e, "rdata", rd(i, p), e);
          end
        end
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; we[p] = '0; addr[p] = '0; wdata[p] = '0; pend[p] = 0;
      part[0][p] = '0; part[1][p] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        chk(rdy(i, p) === 1'b1, "reset_ready", {31'd0, rdy(i, p)}, 32'd1);
        chk(rv(i, p) === 1'b0, "reset_rvalid", {31'd0, rv(i, p)}, 32'd0);
        chk(rd(i, p) === '0, "reset_rdata", rd(i, p), 32'd0);
      end
    rst = 1'b0;

    for (int w = 0; w < 512; w++) begin
      issue(0, 4'hF, 12'(w * 4), $urandom);
      issue(1, 4'hF, 12'((w + 512) * 4), $urandom);
      tick();
    end

    issue(1, 4'hF, 12'h010, 32'hDEADBEEF); tick();
    issue(0, 4'h0, 12'h010, 32'h0); tick();
    chk(rv(1, 0) === 1'b1, "t1_rvalid", {31'd0, rv(1, 0)}, 32'd1);
    chk(rd(1, 0) === 32'hDEADBEEF, "t1_rdata", rd(1, 0), 32'hDEADBEEF);

    issue(1, 4'hF, 12'h003, 32'hDDCCBBAA); tick();
    chk(rdy(1, 1) === 1'b0, "t2_busy", {31'd0, rdy(1, 1)}, 32'd0);
    tick();
    chk(rdy(1, 1) === 1'b1, "t2_free", {31'd0, rdy(1, 1)}, 32'd1);
    issue(0, 4'h0, 12'h000, 32'h0); tick();
    issue(0, 4'h0, 12'h004, 32'h0); tick();
    chk(rd(1, 0)[23:0] === 24'hDDCCBB, "t2_hi", rd(1, 0), 32'h00DDCCBB);

    issue(0, 4'h0, 12'h003, 32'h0); tick();
    chk(rdy(1, 0) === 1'b0, "t3_busy", {31'd0, rdy(1, 0)}, 32'd0);
    chk(rv(1, 0) === 1'b0, "t3_early", {31'd0, rv(1, 0)}, 32'd0);
    tick();
    chk(rv(1, 0) === 1'b1, "t3_rvalid", {31'd0, rv(1, 0)}, 32'd1);
    chk(rd(1, 0) === 32'hDDCCBBAA, "t3_rdata", rd(1, 0), 32'hDDCCBBAA);

    issue(1, 4'hF, 12'hFFE, 32'h44332211); tick(); tick();
    issue(0, 4'h0, 12'hFFE, 32'h0); tick(); tick();
    chk(rd(1, 0) === 32'h44332211, "t4_wrap", rd(1, 0), 32'h44332211);
    issue(0, 4'h0, 12'h000, 32'h0); tick();
    chk(rd(1, 0)[15:0] === 16'h4433, "t4_word0", rd(1, 0), 32'h4433);

    issue(0, 4'hF, 12'h020, 32'h11111111);
    issue(1, 4'hF, 12'h020, 32'h22222222); tick();
    issue(0, 4'h0, 12'h020, 32'h0); tick();
    chk(rd(1, 0) === 32'h22222222, "t5_bwins", rd(1, 0), 32'h22222222);
    chk(rd(0, 0) === 32'h11111111, "t5_awins", rd(0, 0), 32'h11111111);
    issue(0, 4'hF, 12'h020, 32'h33333333);
    issue(1, 4'h0, 12'h020, 32'h0); tick();
    chk(rd(1, 1) === 32'h22222222, "t5_rfirst1", rd(1, 1), 32'h22222222);
    chk(rd(0, 1) === 32'h11111111, "t5_rfirst0", rd(0, 1), 32'h11111111);

    issue(1, 4'hF, 12'h007, 32'h04030201); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk(rdy(1, 1) === 1'b1, "t6_ready", {31'd0, rdy(1, 1)}, 32'd1);
    chk(rv(1, 1) === 1'b0, "t6_rvalid", {31'd0, rv(1, 1)}, 32'd0);
    chk(rd(1, 1) === '0, "t6_rdata", rd(1, 1), 32'd0);
    issue(0, 4'h0, 12'h004, 32'h0); tick();
    chk(rd(1, 0)[31:24] === 8'h01, "t6_byte7", rd(1, 0), 32'h01);
    issue(0, 4'h0, 12'h008, 32'h0); tick();

    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < 2; p++) begin
        logic [11:0] ad;
        logic [3:0] w;
        ad = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 63))
                                         : 12'($urandom);
        w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        if ($urandom_range(0, 3) != 0) issue(p, w, ad, $urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
      rst = 1'b0;
    end

    repeat (10) tick();
    for (int k = 0; k < 4; k++)
      chk(exq[k].size() == 0, "drain", 32'(exq[k].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
